// File: rtl/mul_seq_ctrl.sv
// Shift-add MUL sequencer beside the EX-stage ALU: stalls the pipeline while iterating, then pulses valid_o.
// Optional early exit on an exhausted multiplier is enabled by defining MUL_EARLY_TERM_EN.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]       MUL_CODE = 3'b110;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             req;
  logic [WIDTH-1:0] sum;

  assign req      = issue_i && (ALUCtrl_i == MUL_CODE) && !flush_i;
  assign sum      = mplier[0] ? (acc + mcand) : acc;
  assign busy_o   = (state != IDLE);
  assign result_o = result_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      acc      <= acc_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      result_q <= result_nxt;
    end
  end

  // result_q is loaded on entry to DONE so it equals acc there and then
  // holds through IDLE even after a later issue clears acc.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    result_nxt = result_q;
    stall_o    = 1'b0;
    valid_o    = 1'b0;
    case (state)
      IDLE: begin
        stall_o = req;
        if (req) begin
          mcand_nxt  = src1_i;
          mplier_nxt = src2_i;
          acc_nxt    = '0;
          count_nxt  = CNT_INIT;
          state_nxt  = RUN;
`ifdef MUL_EARLY_TERM_EN
          if (src2_i == '0) begin
            state_nxt  = DONE;
            result_nxt = '0;
          end
`endif
        end
      end
      RUN: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else begin
          stall_o    = 1'b1;
          acc_nxt    = sum;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          count_nxt  = count - CNT_ONE;
          if (count == CNT_ONE) begin
            state_nxt  = DONE;
            result_nxt = sum;
          end
`ifdef MUL_EARLY_TERM_EN
          if ((mplier >> 1) == '0) begin
            state_nxt  = DONE;
            result_nxt = sum;
          end
`endif
        end
      end
      DONE: begin
        valid_o   = !flush_i;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: latency, stall window, result, non-MUL, flush and async reset.
module tb_mul_seq_ctrl;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue = 1'b0;
  logic [2:0]  alu_ctrl = 3'b000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        stall, busy, valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .issue_i(issue), .ALUCtrl_i(alu_ctrl),
    .src1_i(src1), .src2_i(src2), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .valid_o(valid), .result_o(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one MUL, then watch up to 40 cycles with scrambled operands.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int lat_full, input int lat_et);
    int exp_lat;
    int stall_cnt;
    int valid_at;
    int valid_cnt;
    logic [31:0] res;
    exp_lat   = ET ? lat_et : lat_full;
    stall_cnt = 0;
    valid_at  = -1;
    valid_cnt = 0;
    res       = '0;
    @(posedge clk); #1;
    issue = 1'b1; alu_ctrl = 3'b110; src1 = a; src2 = b;
    @(negedge clk);
    if (stall) stall_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      issue = 1'b0; src1 = $urandom; src2 = $urandom;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (valid) begin
        valid_cnt++;
        if (valid_at < 0) begin
          valid_at = k;
          res = result;
        end
      end
    end
    check({tag, "_valid_cycle"}, 64'(valid_at), 64'(exp_lat));
    check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
    check({tag, "_valid_pulses"}, 64'(valid_cnt), 64'd1);
    check({tag, "_result"}, 64'(res), 64'(exp_r));
    check({tag, "_result_hold"}, 64'(result), 64'(exp_r));
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int vcnt;
    // reset state
    #3;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    do_mul("basic", 32'd7, 32'd6, 32'd42, 33, 4);
    do_mul("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 33);
    do_mul("nine_two", 32'd9, 32'd2, 32'd18, 33, 3);
    do_mul("zero", 32'd1234, 32'd0, 32'd0, 33, 1);

    // non-MUL code with issue held: never stalls, never busy, never valid
    vcnt = 0;
    @(posedge clk); #1;
    issue = 1'b1; alu_ctrl = 3'b001; src1 = 32'd3; src2 = 32'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (stall || busy || valid) vcnt++;
      @(posedge clk); #1;
    end
    check("nonmul_activity", 64'(vcnt), 64'd0);
    check("nonmul_result_hold", 64'(result), 64'd0);
    issue = 1'b0;

    // flush in IDLE blocks acceptance
    @(posedge clk); #1;
    issue = 1'b1; alu_ctrl = 3'b110; src1 = 32'd5; src2 = 32'd5; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    issue = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 64'(busy), 64'd0);

    // flush mid-run at T+10
    @(posedge clk); #1;
    issue = 1'b1; alu_ctrl = 3'b110; src1 = 32'd5; src2 = ET ? 32'h8000_0005 : 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      issue = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", 64'(stall), 64'd0);
    check("flush_busy_in_cycle", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_next", 64'(busy), 64'd0);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("flush_no_valid", 64'(vcnt), 64'd0);
    check("flush_result_hold", 64'(result), 64'd0);

    // async reset at T+5 of an operation
    do_mul("pre_rst", 32'd11, 32'd3, 32'd33, 33, 3);
    @(posedge clk); #1;
    issue = 1'b1; alu_ctrl = 3'b110; src1 = 32'd7; src2 = ET ? 32'h8000_0006 : 32'd6;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      issue = 1'b0;
    end
    @(negedge clk);
    check("pre_async_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_stall", 64'(stall), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_valid", 64'(valid), 64'd0);
    check("async_result", 64'(result), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    do_mul("post_rst", 32'd3, 32'd4, 32'd12, 33, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the MUL operation (ALU control code 3'b110): a shift-add multiplier plus the controller that runs it.
- Sits beside the single-cycle ALU in the EX stage.
- Accepts a MUL issue, holds the pipeline with a stall while it iterates, then presents a one-cycle-valid result for the EX/MEM register.
- Non-MUL ALU codes pass through untouched; the block ignores them.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- issue_i  input  1  the EX stage holds a valid instruction this cycle.
- ALUCtrl_i  input  3  ALU control code; 3'b110 = MUL.
- src1_i  input  WIDTH  multiplicand.
- src2_i  input  WIDTH  multiplier.
- flush_i  input  1  pipeline flush; aborts any operation in flight.
- stall_o  output  1  holds PC, IF/ID and ID/EX.
- busy_o  output  1  sequencer is not IDLE.
- valid_o  output  1  result_o is valid this cycle.
- result_o  output  WIDTH  low WIDTH bits of src1 x src2.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; count, accumulator, multiplicand and multiplier registers = 0.
  - Outputs: stall_o=0, busy_o=0, valid_o=0, result_o=0.
- req = issue_i && (ALUCtrl_i==3'b110) && !flush_i.
- State IDLE:
  - stall_o = req, combinational, so the pipeline freezes in the issue cycle.
  - On req: latch mcand=src1_i, mplier=src2_i, acc=0, count=WIDTH; go to RUN.
- State RUN, each cycle:
  - If mplier[0]=1, acc = acc + mcand, modulo 2^WIDTH.
  - Then mcand shifts left 1, mplier shifts right 1 (logical), count decrements.
  - When count reaches 1 (the last iteration), go to DONE.
  - stall_o=1 for the whole state.
- State DONE:
  - result_o=acc, valid_o=1, stall_o=0.
  - Next cycle goes to IDLE; result_o holds its value, valid_o returns to 0.
  - A new req arriving while in DONE is not accepted in that cycle. stall_o stays 0 in DONE, so the pipeline advances the MUL out of EX.
- Latency without the optional feature: issue cycle T, RUN during T+1..T+WIDTH, valid_o in cycle T+WIDTH+1.
- stall_o is high for WIDTH+1 cycles (T..T+WIDTH).
- Back-to-back MULs: the next MUL reaches EX at T+WIDTH+2 and is accepted from IDLE.
- Flush:
  - flush_i in RUN or DONE forces state=IDLE the next edge; valid_o is not asserted for that operation.
  - stall_o drops combinationally in the flush cycle.
  - flush_i in IDLE blocks acceptance.
- Non-MUL codes, or issue_i=0, in IDLE: no state change, stall_o=0.
- Operand changes on src1_i/src2_i during RUN are ignored; operands are latched at issue.
- Signedness: low-WIDTH product only, identical for signed and unsigned operands; no high-half output.
- busy_o = (state != IDLE).
- Unused state encoding decodes to IDLE behaviour and moves to IDLE on the next edge.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- When defined:
  - In RUN, if the multiplier register after the current shift is 0, go to DONE on that edge, regardless of count.
  - Multiplier 0 at issue goes IDLE -> DONE directly (skips RUN): valid_o at T+1, result 0, stall_o high only in cycle T.
  - Minimum latency is therefore 1 cycle; maximum remains WIDTH+1.
- When undefined: fixed WIDTH RUN cycles as above; no early-exit comparator is synthesised.

Test Plan:
- Basic, WIDTH=32: issue MUL, src1=7, src2=6 -> stall_o high cycles T..T+32, valid_o=1 at T+33, result_o=42.
- Wrap: src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result_o=0x00000001 after the full latency.
- Non-MUL: ALUCtrl_i=3'b001 with issue_i=1 -> stall_o=0, busy_o=0, valid_o never asserts.
- Flush mid-run: issue 5x5, flush_i=1 at T+10 -> stall_o=0 in that cycle, IDLE at T+11, no valid_o pulse.
- Async reset at T+5 of an operation -> all outputs 0 immediately, no clock edge needed.
  - Then issue 3x4 after reset release -> result_o=12.
- Early termination (MUL_EARLY_TERM_EN defined): src1=9, src2=2 -> valid_o at T+3, result_o=18.
  - src2=0 -> valid_o at T+1, result_o=0.
